// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receiver: 16x oversampled 8N1 deframer with one-deep receive buffer
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 baud_en,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd_s;
  logic [TW-1:0]          r_tick;
  logic [TW-1:0]          w_tick_nxt;
  logic [BW-1:0]          r_bit;
  logic [BW-1:0]          w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   w_done;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rda;
  logic                   r_frame_err;
  logic                   r_overrun;

  // Synchronizer resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rxd_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    if (baud_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick == TICK_MID) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick == TICK_END) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tick == TICK_END) begin
            w_done      = 1'b1;
            w_tick_nxt  = '0;
            w_state_nxt = w_rxd_s ? S_IDLE : S_BREAK;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start can be seen.
          if (w_rxd_s) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A completing byte takes priority over a consume strobe in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      r_rx_data   <= r_shift;
      r_rda       <= 1'b1;
      r_frame_err <= ~w_rxd_s;
      r_overrun   <= r_rda & ~rd;
    end else if (rd && r_rda) begin
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rda       = r_rda;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - self-checking bench for spart_rx against a tick-arithmetic frame model
module tb_spart_rx;

  localparam int DB      = 8;
  localparam int OS      = 16;
  localparam int SYNC    = 2;
  localparam int BIT_CLK = 64;
  localparam int EL_STOP = OS / 2 + (DB + 1) * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          baud_en = 1'b0;
  logic          rd = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rda;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  spart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .baud_en  (baud_en),
    .rd       (rd),
    .rx_data  (rx_data),
    .rda      (rda),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;
  int rd_hits = 0;
  logic saw_busy = 1'b0;

  // Model: line history as seen after the synchronizer, plus elapsed-tick arithmetic per frame.
  logic [SYNC-1:0] m_hist = '1;
  logic            m_active = 1'b0;
  logic            m_brk = 1'b0;
  int              m_tick = 0;
  int              m_start = 0;
  int              m_ncomp = 0;
  logic [DB-1:0]   m_bits = '0;
  logic [DB-1:0]   e_data = '0;
  logic            e_rda = 1'b0;
  logic            e_fe = 1'b0;
  logic            e_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_hist   = '1;
    m_active = 1'b0;
    m_brk    = 1'b0;
    m_bits   = '0;
    e_data   = '0;
    e_rda    = 1'b0;
    e_fe     = 1'b0;
    e_ov     = 1'b0;
  endtask

  task automatic model_edge();
    logic s;
    logic done;
    logic stop;
    int   el;
    s      = m_hist[SYNC-1];
    m_hist = {m_hist[SYNC-2:0], rxd};
    done   = 1'b0;
    stop   = 1'b1;
    if (baud_en) begin
      m_tick++;
      if (m_brk) begin
        m_brk = !s;
      end else if (!m_active) begin
        if (!s) begin
          m_active = 1'b1;
          m_start  = m_tick;
        end
      end else begin
        el = m_tick - m_start;
        if (el == OS / 2) begin
          if (s) m_active = 1'b0;
        end else if (el == EL_STOP) begin
          done     = 1'b1;
          stop     = s;
          m_active = 1'b0;
          m_brk    = !s;
        end else if (el > OS / 2 && (el - OS / 2) % OS == 0) begin
          m_bits[(el - OS / 2) / OS - 1] = s;
        end
      end
    end
    if (done) begin
      e_ov   = e_rda & !rd;
      e_rda  = 1'b1;
      e_fe   = !stop;
      e_data = m_bits;
      m_ncomp++;
    end else if (rd && e_rda) begin
      e_rda = 1'b0;
      e_fe  = 1'b0;
      e_ov  = 1'b0;
    end
  endtask

  // rd_mode: 0 none, 1 pulse, 2 random, 3 only on the cycle a byte completes.
  task automatic step(input logic line, input int rd_mode);
    rxd     = line;
    baud_en = (ph % 4 == 3);
    ph++;
    case (rd_mode)
      1:       rd = 1'b1;
      2:       rd = ($urandom_range(0, 15) == 0);
      3:       rd = m_active && (m_tick - m_start == EL_STOP - 1) && baud_en;
      default: rd = 1'b0;
    endcase
    if (rd_mode == 3 && rd) rd_hits++;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    @(negedge clk);
    if (rst) begin
      if (busy) saw_busy = 1'b1;
      chk("cycle", 32'({rx_data, rda, frame_err, overrun, busy}),
          32'({e_data, e_rda, e_fe, e_ov, m_active | m_brk}));
    end
  endtask

  task automatic idle(input int n, input int rd_mode);
    for (int i = 0; i < n; i++) step(1'b1, rd_mode);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int rd_mode,
                            input int abort_bit);
    for (int i = 0; i < BIT_CLK; i++) step(1'b0, rd_mode);
    for (int k = 0; k < DB; k++) begin
      if (k == abort_bit) begin
        for (int i = 0; i < BIT_CLK / 2; i++) step(b[k], rd_mode);
        return;
      end
      for (int i = 0; i < BIT_CLK; i++) step(b[k], rd_mode);
    end
    for (int i = 0; i < BIT_CLK; i++) step(stop, rd_mode);
  endtask

  initial begin
    int c0;
    logic [DB-1:0] rb;
    logic rs;
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rda", 32'(rda), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    idle(3, 0);
    rst = 1'b1;
    idle(100, 0);

    send_frame(8'h99, 1'b1, 0, -1);
    idle(40, 0);
    chk("clean_data", 32'(rx_data), 32'h99);
    chk("clean_rda", 32'(rda), 32'h1);
    chk("clean_fe", 32'(frame_err), 32'h0);
    chk("clean_ov", 32'(overrun), 32'h0);
    step(1'b1, 1);
    chk("clean_rd_clears", 32'(rda), 32'h0);
    idle(20, 0);

    saw_busy = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, 0);
    idle(80, 0);
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_no_rda", 32'(rda), 32'h0);
    chk("glitch_idle", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1, 0, -1);
    idle(40, 0);
    chk("after_glitch_data", 32'(rx_data), 32'h5A);
    chk("after_glitch_rda", 32'(rda), 32'h1);
    step(1'b1, 1);
    idle(20, 0);

    c0 = m_ncomp;
    send_frame(8'h3C, 1'b0, 0, -1);
    for (int i = 0; i < 40 * 4; i++) step(1'b0, 0);
    idle(64, 0);
    chk("ferr_data", 32'(rx_data), 32'h3C);
    chk("ferr_flag", 32'(frame_err), 32'h1);
    chk("ferr_rda", 32'(rda), 32'h1);
    chk("ferr_single_ov", 32'(overrun), 32'h0);
    chk("ferr_model_once", 32'(m_ncomp - c0), 32'h1);
    step(1'b1, 1);
    send_frame(8'hA5, 1'b1, 0, -1);
    idle(40, 0);
    chk("after_ferr_data", 32'(rx_data), 32'hA5);
    chk("after_ferr_fe", 32'(frame_err), 32'h0);
    step(1'b1, 1);
    idle(20, 0);

    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(40, 0);
    chk("ovr_data", 32'(rx_data), 32'h22);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_rda", 32'(rda), 32'h1);
    step(1'b1, 1);
    chk("ovr_clear", 32'({rda, frame_err, overrun}), 32'h0);
    idle(20, 0);

    send_frame(8'h66, 1'b1, 0, -1);
    send_frame(8'h77, 1'b1, 3, -1);
    idle(40, 0);
    chk("simul_rd_hit", 32'(rd_hits), 32'h1);
    chk("simul_rda", 32'(rda), 32'h1);
    chk("simul_data", 32'(rx_data), 32'h77);
    chk("simul_ov", 32'(overrun), 32'h0);
    step(1'b1, 1);
    idle(20, 0);

    send_frame(8'h81, 1'b1, 0, -1);
    idle(20, 0);
    send_frame(8'hF0, 1'b1, 0, 4);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_reset_outputs", 32'({rx_data, rda, frame_err, overrun, busy}), 32'h0);
    @(negedge clk);
    idle(3, 0);
    rst = 1'b1;
    idle(30, 0);
    send_frame(8'h0F, 1'b1, 0, -1);
    idle(40, 0);
    chk("post_reset_data", 32'(rx_data), 32'h0F);
    chk("post_reset_rda", 32'(rda), 32'h1);
    chk("post_reset_fe", 32'(frame_err), 32'h0);
    step(1'b1, 1);
    idle(20, 0);

    c0 = m_ncomp;
    for (int f = 0; f < 25; f++) begin
      rb = DB'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rs, 2, -1);
      if (!rs) begin
        for (int i = 0; i < int'($urandom_range(0, 100)); i++) step(1'b0, 2);
      end
      idle(int'($urandom_range(0, 80)), 2);
    end
    idle(40, 0);
    chk("random_completions", 32'(m_ncomp - c0), 32'd25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART. Oversamples the asynchronous `rxd` line on the baud generator's 16x enable tick and recovers 8N1 frames, LSB first.
- Holds each received byte in a one-deep receive buffer for the bus-interface stage.
- Downstream consumer reads the byte via `rd`. `rda`, `frame_err` and `overrun` feed the SPART status register.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, `baud_en` ticks per bit period; must be even and >= 4.
- SYNC_STAGES, 2, flip-flop stages in the `rxd` synchronizer.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- rxd  input  1  serial receive line, idle high, asynchronous to clk
- baud_en  input  1  single-cycle oversample tick from baud generator
- rd  input  1  single-cycle consume strobe; clears rda/frame_err/overrun
- rx_data  output  DATA_BITS  last received byte
- rda  output  1  receive data available
- frame_err  output  1  stop bit of last byte sampled low
- overrun  output  1  byte completed while rda was already set
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - Synchronizer flops reset to 1.
  - State = IDLE; tick and bit counters = 0; shift register = 0.
  - rx_data = 0; rda = 0; frame_err = 0; overrun = 0; busy = 0.
  - Reset mid-frame aborts the frame with no partial output.
- Synchronizer: `rxd` passes through SYNC_STAGES flops. All decisions below use the synchronized value `rxd_s`.
- Tick counter: advances only on cycles with baud_en = 1. States hold when baud_en = 0.
- IDLE: on a baud_en tick with rxd_s = 0, go to START with tick_cnt = 0.
- START: on the baud_en tick where tick_cnt = OVERSAMPLE/2-1 (mid start bit), sample rxd_s.
  - 0: go to DATA; tick_cnt = 0; bit_cnt = 0.
  - 1: false start; return to IDLE with no output.
- DATA: on the baud_en tick where tick_cnt = OVERSAMPLE-1, sample rxd_s.
  - Shift it into the MSB of the shift register (shift right, LSB first); tick_cnt = 0; bit_cnt++.
  - After DATA_BITS samples, go to STOP.
- STOP: on the baud_en tick where tick_cnt = OVERSAMPLE-1, sample the stop bit.
  - On the next clk edge: rx_data <= shift register; rda <= 1; frame_err <= ~rxd_s.
  - Stop = 1: go to IDLE.
  - Stop = 0: go to BREAK.
- BREAK: wait for a baud_en tick with rxd_s = 1, then go to IDLE. A held-low line yields exactly one frame_err byte, no repeated frames.
- Latency: rda rises one clk after the stop-bit sample tick, i.e. (1+DATA_BITS)*OVERSAMPLE + OVERSAMPLE/2 ticks after the start edge is seen, plus SYNC_STAGES clk of synchronizer delay.
- Overrun: if a byte completes while rda = 1 and rd = 0, then overrun <= 1 and rx_data is overwritten with the new byte (newest wins).
- rd while rda = 1 and no completion: rda, frame_err, overrun <= 0 on the next edge.
- rd with rda = 0: no effect.
- rd in the same cycle as a completion: the completion wins. rda stays 1; frame_err reflects the new byte; overrun <= 0.
- rx_data is stable whenever rda = 1, except on an overwrite.
- busy is combinational from state; it has no effect on rda.

Test Plan:
- Clean byte: baud_en every 4 clk, OVERSAMPLE = 16; drive frame 0x99 (start 0, bits 1,0,0,1,1,0,0,1, stop 1) at 64 clk/bit -> rda = 1, rx_data = 0x99, frame_err = 0, overrun = 0, rise within 2 clk of the mid-stop tick; rd pulse -> rda = 0 next clk.
- False start: 4-tick (16 clk) low glitch on an idle line -> busy pulses, returns to IDLE, rda stays 0; a following 0x5A frame is received correctly.
- Framing error: frame 0x3C with stop bit 0, line held low 40 more ticks then released -> rda = 1, rx_data = 0x3C, frame_err = 1; exactly one completion; next frame 0xA5 -> frame_err = 0.
- Overrun: receive 0x11 and 0x22 back-to-back without rd -> rx_data = 0x22, overrun = 1, rda = 1; rd -> all three flags clear.
- Simultaneous rd and completion: assert rd on the cycle 0x77 completes while 0x66 is held -> rda = 1, rx_data = 0x77, overrun = 0.
- Reset mid-frame: rst low during data bit 4 of 0xF0 -> all outputs 0 immediately (asynchronous), state IDLE; after release, 0x0F is received correctly.
